// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM/IO bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {StIdle, StIcRd, StLsRd, StLsWr} state_e;

    typedef enum logic {GntIc, GntLs} grant_e;

    localparam logic [1:0] LenByte     = 2'd0;
    localparam logic [1:0] LenHalf     = 2'd1;
    localparam logic [1:0] LenWord     = 2'd2;
    localparam logic [1:0] IoHiDefault = 2'b11;

    // Encoding 3 is treated as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LenByte: return 3'd1;
            LenHalf: return 3'd2;
            LenWord: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the byte-wide RAM/IO bus between ICache fetches and LSB loads/stores,
// serialising each request into byte cycles and assembling read data.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [1:0]  IO_HI    = IoHiDefault,
    parameter int unsigned IC_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        ic_valid,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_len,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    localparam logic [2:0] IcN = 3'(IC_BYTES);

    state_e      state_q, state_d;
    grant_e      last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        ic_done_q, ic_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] a_hold_q;
    logic [7:0]  dout_hold_q;

    logic [31:0] a_live;
    logic [7:0]  dout_live;
    logic        wr_live;
    logic        base_is_io, ls_is_io, idle_ok, pick_ls, stall, abort;
    logic [1:0]  rd_idx;

    assign base_is_io = (base_q[17:16] == IO_HI);
    assign ls_is_io   = (ls_addr[17:16] == IO_HI);
    assign idle_ok    = !rst && !flush && !ic_done_q && !ls_done_q && (ic_valid || ls_valid);
    assign pick_ls    = ls_valid && (!ic_valid || last_q == GntIc);
    // Byte landing this cycle is the one addressed in the previous cycle.
    assign rd_idx     = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        nbytes_d  = nbytes_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        ic_done_d = 1'b0;
        ls_done_d = 1'b0;
        a_live    = base_q + {29'd0, cnt_q};
        dout_live = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        wr_live   = 1'b0;
        stall     = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (idle_ok) begin
                    data_d = '0;
                    cnt_d  = 3'd1;
                    if (pick_ls) begin
                        last_d    = GntLs;
                        base_d    = ls_addr;
                        nbytes_d  = len_bytes(ls_len);
                        wdata_d   = ls_wdata;
                        a_live    = ls_addr;
                        dout_live = ls_wdata[7:0];
                        if (ls_wr) begin
                            stall   = ls_is_io && io_buffer_full;
                            wr_live = !stall;
                            if (stall) begin
                                state_d = StLsWr;
                                cnt_d   = 3'd0;
                            end else if (len_bytes(ls_len) == 3'd1) begin
                                cnt_d     = 3'd0;
                                ls_done_d = 1'b1;
                            end else begin
                                state_d = StLsWr;
                            end
                        end else begin
                            state_d = StLsRd;
                        end
                    end else begin
                        last_d   = GntIc;
                        base_d   = ic_addr;
                        nbytes_d = IcN;
                        a_live   = ic_addr;
                        state_d  = StIcRd;
                    end
                end
            end
            StIcRd, StLsRd: begin
                data_d[{rd_idx, 3'b000} +: 8] = mem_din;
                // IO reads have side effects, so only RAM reads are abortable.
                abort = flush && (state_q == StIcRd || !base_is_io);
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else if (cnt_q == nbytes_q) begin
                    state_d   = StIdle;
                    cnt_d     = 3'd0;
                    ic_done_d = (state_q == StIcRd);
                    ls_done_d = (state_q == StLsRd);
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StLsWr: begin
                stall   = base_is_io && io_buffer_full;
                wr_live = !stall;
                if (!stall) begin
                    if (cnt_q == nbytes_q - 3'd1) begin
                        state_d   = StIdle;
                        cnt_d     = 3'd0;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= GntIc;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            ic_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            a_hold_q    <= '0;
            dout_hold_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            ic_done_q   <= ic_done_d;
            ls_done_q   <= ls_done_d;
            a_hold_q    <= a_live;
            dout_hold_q <= dout_live;
        end
    end

    // While paused the bus keeps presenting the last active address, so the
    // byte returned on resume is still the one the counter expects.
    assign mem_a    = rst ? '0 : (rdy ? a_live : a_hold_q);
    assign mem_dout = rst ? '0 : (rdy ? dout_live : dout_hold_q);
    assign mem_wr   = !rst && rdy && wr_live;
    assign ic_done  = ic_done_q;
    assign ls_done  = ls_done_q;
    assign ic_data  = data_q;
    assign ls_rdata = data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: byte-addressed RAM model, directed
// vectors, multi-cycle corner sequences and randomised transactions.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ic_valid, ic_done, ls_valid, ls_wr, ls_done;
    logic [31:0] ic_addr, ic_data, ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_len;

    mem_bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .flush          (flush),
        .ic_valid       (ic_valid),
        .ic_addr        (ic_addr),
        .ic_done        (ic_done),
        .ic_data        (ic_data),
        .ls_valid       (ls_valid),
        .ls_wr          (ls_wr),
        .ls_addr        (ls_addr),
        .ls_len         (ls_len),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    wr_t        wlog[$];
    bit [7:0]   ram[bit [31:0]];
    bit [7:0]   ref_mem[bit [31:0]];

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return def_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_byte(a);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM/IO model: address sampled mid-cycle, data returned the next cycle.
    logic [7:0] din_nx;
    initial forever begin
        @(negedge clk);
        din_nx = rd_byte(mem_a);
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wlog.push_back('{a: mem_a, d: mem_dout, c: cyc});
        end
        @(posedge clk);
        mem_din <= din_nx;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_wr(input string name, input int idx, input logic [31:0] a,
                            input logic [7:0] d, input int c);
        n_tests++;
        if (idx >= wlog.size()) begin
            n_fail++;
            $display("FAIL %s: write %0d missing, expected %h@%h cycle %0d", name, idx, d, a, c);
        end else if (wlog[idx].a !== a || wlog[idx].d !== d || wlog[idx].c != c) begin
            n_fail++;
            $display("FAIL %s: got %h@%h cycle %0d, expected %h@%h cycle %0d", name,
                     wlog[idx].d, wlog[idx].a, wlog[idx].c, d, a, c);
        end
    endtask

    // Issue one request in the current cycle (G) and wait for its done pulse.
    // Masks give per-cycle flush / io_buffer_full / pause (rdy low) from G.
    task automatic run_req(input bit is_ic, input bit wr, input logic [31:0] a,
                           input logic [1:0] len, input logic [31:0] wd,
                           input logic [15:0] fl_m, input logic [15:0] full_m,
                           input logic [15:0] pause_m,
                           output logic [31:0] rd, output int lat, output int g);
        g   = cyc;
        lat = -1;
        rd  = '0;
        if (is_ic) begin
            ic_valid = 1'b1;
            ic_addr  = a;
        end else begin
            ls_valid = 1'b1;
            ls_wr    = wr;
            ls_addr  = a;
            ls_len   = len;
            ls_wdata = wd;
        end
        for (int i = 0; i < 16; i++) begin
            flush          = fl_m[i];
            io_buffer_full = full_m[i];
            rdy            = !pause_m[i];
            @(negedge clk);
            if (is_ic ? ic_done : ls_done) begin
                lat = i;
                rd  = is_ic ? ic_data : ls_rdata;
            end
            @(posedge clk);
            #1;
            if (lat >= 0) break;
        end
        flush = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
        ic_valid = 1'b0; ls_valid = 1'b0;
    endtask

    // Both requesters raise valid together; each drops valid after its done.
    task automatic run_tie(output int ls_at, output int ic_at,
                           output logic [31:0] ls_d, output logic [31:0] ic_d);
        ls_at = -1; ic_at = -1; ls_d = '0; ic_d = '0;
        ic_valid = 1'b1; ic_addr = 32'h100;
        ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h200; ls_len = 2'd2;
        for (int i = 0; i < 30 && (ls_at < 0 || ic_at < 0); i++) begin
            @(negedge clk);
            if (ls_done && ls_at < 0) begin ls_at = i; ls_d = ls_rdata; end
            if (ic_done && ic_at < 0) begin ic_at = i; ic_d = ic_data; end
            @(posedge clk);
            #1;
            if (ls_at >= 0) ls_valid = 1'b0;
            if (ic_at >= 0) ic_valid = 1'b0;
        end
        ic_valid = 1'b0; ls_valid = 1'b0;
    endtask

    typedef struct {
        bit          is_ic;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rd, rd2, exp, addr, wd;
    int          lat, lat2, g, n;
    bit          is_ic, wr;
    logic [1:0]  len;

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        ic_valid = 1'b0; ic_addr = '0;
        ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h40; ls_len = 2'd0; ls_wdata = 32'h77;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("reset_mem_a", mem_a, 32'd0);
        check("reset_dones", {30'd0, ic_done, ls_done}, 32'd0);
        check("reset_data", ic_data | ls_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ls_valid = 1'b0;

        // Tie after reset: LS first, IC the cycle after LS drops valid.
        run_tie(lat, lat2, rd, rd2);
        check("tie1_ls_at", 32'(lat), 32'd5);
        check("tie1_ic_at", 32'(lat2), 32'd11);
        check("tie1_ls_data", rd, 32'h44332211);
        check("tie1_ic_data", rd2, 32'h00000513);
        run_req(0, 0, 32'h200, 2'd0, '0, '0, '0, '0, rd, lat, g);
        run_tie(lat, lat2, rd, rd2);
        check("tie2_ic_at", 32'(lat2), 32'd5);
        check("tie2_ls_at", 32'(lat), 32'd11);

        // Fetch: no writes, done at G+5.
        wlog.delete();
        run_req(1, 0, 32'h100, 2'd0, '0, '0, '0, '0, rd, lat, g);
        check("fetch_data", rd, 32'h00000513);
        check("fetch_lat", 32'(lat), 32'd5);
        check("fetch_no_wr", 32'(wlog.size()), 32'd0);

        // Halfword store on consecutive cycles.
        wlog.delete();
        run_req(0, 1, 32'h2001, 2'd1, 32'h0000BEEF, '0, '0, '0, rd, lat, g);
        check("sh_lat", 32'(lat), 32'd2);
        check("sh_count", 32'(wlog.size()), 32'd2);
        check_wr("sh_b0", 0, 32'h2001, 8'hEF, g);
        check_wr("sh_b1", 1, 32'h2002, 8'hBE, g + 1);

        vecs.push_back('{0, 0, 32'h200,      2'd2, 32'h0,        32'h44332211, 5});
        vecs.push_back('{0, 0, 32'h201,      2'd1, 32'h0,        32'h00003322, 3});
        vecs.push_back('{0, 0, 32'h203,      2'd0, 32'h0,        32'h00000044, 2});
        vecs.push_back('{0, 1, 32'h2001,     2'd1, 32'hDEADBEEF, 32'h0,        2});
        vecs.push_back('{0, 0, 32'h2001,     2'd1, 32'h0,        32'h0000BEEF, 3});
        vecs.push_back('{0, 0, 32'h200,      2'd3, 32'h0,        32'h44332211, 5});
        vecs.push_back('{0, 1, 32'h300,      2'd2, 32'hCAFEF00D, 32'h0,        4});
        vecs.push_back('{1, 0, 32'h300,      2'd0, 32'h0,        32'hCAFEF00D, 5});
        vecs.push_back('{0, 0, 32'h2000,     2'd2, 32'h0,        32'h59BEEF5A, 5});
        vecs.push_back('{0, 1, 32'hFFFFFFFF, 2'd1, 32'h00001234, 32'h0,        2});
        vecs.push_back('{0, 0, 32'hFFFFFFFF, 2'd1, 32'h0,        32'h00001234, 3});
        vecs.push_back('{0, 1, 32'h0,        2'd0, 32'h000000A7, 32'h0,        1});
        vecs.push_back('{0, 0, 32'hFFFFFFFF, 2'd1, 32'h0,        32'h0000A734, 3});
        foreach (vecs[i]) begin
            run_req(vecs[i].is_ic, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata,
                    '0, '0, '0, rd, lat, g);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            if (!vecs[i].wr) check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
        end

        // IO stall: buffer full for three cycles from the grant.
        wlog.delete();
        run_req(0, 1, 32'h30000, 2'd0, 32'h41, '0, 16'h0007, '0, rd, lat, g);
        check("io_lat", 32'(lat), 32'd4);
        check("io_count", 32'(wlog.size()), 32'd1);
        check_wr("io_byte", 0, 32'h30000, 8'h41, g + 3);

        // Flush at k=2 of a fetch: IDLE next cycle, held request regranted.
        run_req(1, 0, 32'h100, 2'd0, '0, 16'h0004, '0, '0, rd, lat, g);
        check("flush_fetch_lat", 32'(lat), 32'd8);
        check("flush_fetch_data", rd, 32'h00000513);
        // Flush coinciding with the final capture suppresses that done.
        run_req(1, 0, 32'h100, 2'd0, '0, 16'h0010, '0, '0, rd, lat, g);
        check("flush_last_lat", 32'(lat), 32'd10);
        run_req(0, 0, 32'h200, 2'd2, '0, 16'h0002, '0, '0, rd, lat, g);
        check("flush_load_lat", 32'(lat), 32'd7);
        run_req(0, 0, 32'h30010, 2'd2, '0, 16'h0004, '0, '0, rd, lat, g);
        check("flush_io_rd_lat", 32'(lat), 32'd5);
        check("flush_io_rd_data", rd, 32'h49484B4A);
        wlog.delete();
        run_req(0, 1, 32'h400, 2'd2, 32'h87654321, 16'h0006, '0, '0, rd, lat, g);
        check("flush_st_lat", 32'(lat), 32'd4);
        check_wr("flush_st_b0", 0, 32'h400, 8'h21, g);
        check_wr("flush_st_b3", 3, 32'h403, 8'h87, g + 3);

        // rdy low mid-load and mid-store.
        run_req(0, 0, 32'h200, 2'd2, '0, '0, '0, 16'h000C, rd, lat, g);
        check("pause_ld_lat", 32'(lat), 32'd7);
        check("pause_ld_data", rd, 32'h44332211);
        wlog.delete();
        run_req(0, 1, 32'h500, 2'd2, 32'h11223344, '0, '0, 16'h0002, rd, lat, g);
        check("pause_st_lat", 32'(lat), 32'd5);
        check("pause_st_count", 32'(wlog.size()), 32'd4);
        check_wr("pause_st_b1", 1, 32'h501, 8'h33, g + 2);
        check_wr("pause_st_b3", 3, 32'h503, 8'h11, g + 4);

        // Reset in the middle of a store drops mem_wr at once.
        wlog.delete();
        ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h600; ls_len = 2'd2;
        ls_wdata = 32'h0A0B0C0D;
        @(posedge clk);
        #1;
        check("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        ls_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_partial", 32'(wlog.size()), 32'd1);
        check("rst_no_done", {31'd0, ls_done}, 32'd0);
        @(posedge clk);
        #1;

        // Random transactions against a byte-level reference memory.
        for (int t = 0; t < 80; t++) begin
            is_ic = ($urandom_range(0, 3) == 0);
            wr    = !is_ic && ($urandom_range(0, 1) == 1);
            addr  = 32'h8000 + $urandom_range(0, 31);
            len   = 2'($urandom_range(0, 3));
            wd    = $urandom;
            n     = is_ic ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
            exp   = '0;
            for (int j = 0; j < n; j++) begin
                if (wr) ref_mem[addr + 32'(j)] = wd[8*j +: 8];
                else    exp[8*j +: 8] = ref_rd(addr + 32'(j));
            end
            run_req(is_ic, wr, addr, len, wd, '0, '0, '0, rd, lat, g);
            check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(wr ? n : n + 1));
            if (!wr) check($sformatf("rnd%0d_data", t), rd, exp);
        end
        for (int a = 32'h8000; a < 32'h8024; a++) begin
            check($sformatf("ram_%h", a), {24'd0, rd_byte(32'(a))}, {24'd0, ref_rd(32'(a))});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
